// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: operands are stepped LSB-first through one full-adder slice
// built from two half adders, with a carry flop and valid/ready handshakes.

module half_adder (
  input  logic a_i,
  input  logic b_i,
  output logic sum_o,
  output logic carry_o
);
  assign sum_o   = a_i ^ b_i;
  assign carry_o = a_i & b_i;
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_sh_q, b_sh_q, sum_sh_q, sum_q;
  logic [WIDTH-1:0] sum_sh_d;
  logic [CW-1:0]    bit_cnt_q;
  logic             carry_q, carry_out_q;
  logic             in_ready_q, out_valid_q, busy_q;

  logic ha0_sum, ha0_carry, ha1_sum, ha1_carry;
  logic slice_sum, slice_carry;

  half_adder u_ha0 (
    .a_i     (a_sh_q[0]),
    .b_i     (b_sh_q[0]),
    .sum_o   (ha0_sum),
    .carry_o (ha0_carry)
  );

  half_adder u_ha1 (
    .a_i     (ha0_sum),
    .b_i     (carry_q),
    .sum_o   (ha1_sum),
    .carry_o (ha1_carry)
  );

  assign slice_sum   = ha1_sum;
  assign slice_carry = ha0_carry | ha1_carry;

  // Written as shifts so a WIDTH of 1 needs no zero-length slice.
  assign sum_sh_d = (sum_sh_q >> 1) | (WIDTH'(slice_sum) << (WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      sum_sh_q    <= '0;
      carry_q     <= 1'b0;
      bit_cnt_q   <= '0;
      sum_q       <= '0;
      carry_out_q <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_sh_q     <= a;
            b_sh_q     <= b;
            sum_sh_q   <= '0;
            carry_q    <= 1'b0;
            bit_cnt_q  <= '0;
            state_q    <= RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        RUN: begin
          a_sh_q    <= a_sh_q >> 1;
          b_sh_q    <= b_sh_q >> 1;
          sum_sh_q  <= sum_sh_d;
          carry_q   <= slice_carry;
          bit_cnt_q <= bit_cnt_q + CW'(1);
          // Results are captured on the final bit so they hold until the next op.
          if (bit_cnt_q == CW'(WIDTH - 1)) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            sum_q       <= sum_sh_d;
            carry_out_q <= slice_carry;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign sum       = sum_q;
  assign carry_out = carry_out_q;

endmodule
